dll_tx_scheduler: RTL and testbench

- Transmit-side scheduler of the Data Link Layer. Shares the single 256-bit PIPE transmit word between three sources: the TLP stream from the retry buffer, ACK/NAK DLLPs, and FC DLLPs (InitFC/UpdateFC).
- Never splits a TLP. Gates TLP traffic on DL_up and bounds TLP starvation by DLLP bursts.
- Drives a registered, backpressurable output toward the PHY.

---
 rtl/dll_pkg.sv | 26 ++
 rtl/dll_tx_out_reg.sv | 46 ++++
 rtl/dll_tx_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_dll_tx_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dll_pkg.sv
// dll_pkg
// Shared types and default sizes for the Data Link Layer transmit path.
//   PIPE_DATA_WIDTH_DFLT  default width of one PIPE beat (32B)
//   DLLP_BURST_MAX_DFLT   default DLLP burst bound while a TLP sop waits
//   FC_TIMER_CYCLES_DFLT  default UpdateFC watchdog period
//   sel_t                 source tag of the word on the PIPE output
//   sched_state_t         scheduler packet-boundary state
package dll_pkg;

  localparam int PIPE_DATA_WIDTH_DFLT = 256;
  localparam int DLLP_BURST_MAX_DFLT  = 4;
  localparam int FC_TIMER_CYCLES_DFLT = 1024;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_TLP  = 2'd1,
    SEL_ACKN = 2'd2,
    SEL_FC   = 2'd3
  } sel_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_TLP  = 1'b1
  } sched_state_t;

endpackage

// File: rtl/dll_tx_out_reg.sv
// dll_tx_out_reg
// Backpressurable output register toward the PHY. A new word (or a bubble)
// is loaded only when the register is empty or the PHY takes the current word.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load_valid    a word is being accepted this cycle
//   load_sel      source tag of that word
//   load_data     the word itself
//   pipe_ready    PHY accepts the current word
//   adv           register may load this cycle
//   data/valid/sel registered word, valid flag and source tag
module dll_tx_out_reg
  import dll_pkg::*;
#(
  parameter int WIDTH = PIPE_DATA_WIDTH_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  sel_t             load_sel,
  input  logic [WIDTH-1:0] load_data,
  input  logic             pipe_ready,
  output logic             adv,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output sel_t             sel
);

  assign adv = !valid || pipe_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
      sel   <= SEL_NONE;
    end else if (adv) begin
      valid <= load_valid;
      sel   <= load_valid ? load_sel : SEL_NONE;
      // On a bubble the data bits keep their last value.
      if (load_valid) begin
        data <= load_data;
      end
    end
  end

endmodule

// File: rtl/dll_tx_scheduler.sv
// dll_tx_scheduler
// Transmit-side DLL scheduler: shares one PIPE word per cycle between the
// retry-buffer TLP stream, ACK/NAK DLLPs and FC DLLPs. TLPs are never split,
// TLP traffic needs DL_up, and DLLP bursts ahead of a waiting TLP sop are
// bounded by DLLP_BURST_MAX.
// Optional feature macro: DLL_SCHED_FC_TIMER_EN (UpdateFC watchdog; when
// undefined fc_timeout_o is tied low and priority is fixed).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   dl_up_i                        DL_up from the DLCMSM
//   tlp_valid/sop/eop/data_i       TLP beat from the retry buffer
//   tlp_ready_o                    TLP beat accepted this cycle
//   ackn_req_i/ackn_data_i         pending ACK/NAK word (held until grant)
//   ackn_gnt_o                     ACK/NAK word accepted this cycle
//   fc_req_i/fc_data_i             pending FC word (held until grant)
//   fc_gnt_o                       FC word accepted this cycle
//   pipe_data_o/pipe_valid_o       registered word to the PHY
//   pipe_ready_i                   PHY accepts the word
//   sel_o                          source of pipe_data_o (0 none,1 TLP,2 ACK/NAK,3 FC)
//   err_o                          one-cycle protocol error pulse
//   fc_timeout_o                   UpdateFC watchdog pulse
//
// state  | meaning
// S_IDLE | at a packet boundary; DLLPs and TLP sop compete for the word
// S_TLP  | inside a TLP; only its beats are granted until eop
module dll_tx_scheduler
  import dll_pkg::*;
#(
  parameter int PIPE_DATA_WIDTH = PIPE_DATA_WIDTH_DFLT,
  parameter int DLLP_BURST_MAX  = DLLP_BURST_MAX_DFLT,
  parameter int FC_TIMER_CYCLES = FC_TIMER_CYCLES_DFLT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dl_up_i,
  input  logic                       tlp_valid_i,
  input  logic                       tlp_sop_i,
  input  logic                       tlp_eop_i,
  input  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i,
  output logic                       tlp_ready_o,
  input  logic                       ackn_req_i,
  input  logic [PIPE_DATA_WIDTH-1:0] ackn_data_i,
  output logic                       ackn_gnt_o,
  input  logic                       fc_req_i,
  input  logic [PIPE_DATA_WIDTH-1:0] fc_data_i,
  output logic                       fc_gnt_o,
  output logic [PIPE_DATA_WIDTH-1:0] pipe_data_o,
  output logic                       pipe_valid_o,
  input  logic                       pipe_ready_i,
  output logic [1:0]                 sel_o,
  output logic                       err_o,
  output logic                       fc_timeout_o
);

  localparam int CNT_W = $clog2(DLLP_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DLLP_BURST_MAX);

  sched_state_t               state;
  sched_state_t               state_nxt;
  logic                       adv;
  logic [CNT_W-1:0]           dllp_cnt;
  logic                       gnt_tlp;
  logic                       gnt_ackn;
  logic                       gnt_fc;
  logic                       fwd;
  sel_t                       fwd_sel;
  logic [PIPE_DATA_WIDTH-1:0] fwd_data;
  logic                       err_nxt;
  logic                       err_q;
  logic                       sop_wait;
  logic                       starved;
  logic                       fc_boost;
  sel_t                       sel_q;

  assign sop_wait = tlp_valid_i && tlp_sop_i;
  assign starved  = (dllp_cnt >= CNT_MAX) && sop_wait;

  always_comb begin
    state_nxt = state;
    gnt_tlp   = 1'b0;
    gnt_ackn  = 1'b0;
    gnt_fc    = 1'b0;
    err_nxt   = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (adv) begin
            if (!dl_up_i) begin
              // Link down: only InitFC traffic may go out.
              gnt_fc = fc_req_i;
            end else if (starved) begin
              gnt_tlp = 1'b1;
            end else if (fc_boost && fc_req_i) begin
              gnt_fc = 1'b1;
            end else if (ackn_req_i) begin
              gnt_ackn = 1'b1;
            end else if (fc_req_i) begin
              gnt_fc = 1'b1;
            end else if (tlp_valid_i) begin
              gnt_tlp = 1'b1;
            end
            if (gnt_tlp) begin
              // A non-sop beat at a boundary is consumed and dropped.
              if (!tlp_sop_i) begin
                err_nxt = 1'b1;
              end else if (!tlp_eop_i) begin
                state_nxt = S_TLP;
              end
            end
          end
        end
        S_TLP: begin
          if (!dl_up_i) begin
            // Truncate the packet; the retry buffer replays it later.
            state_nxt = S_IDLE;
          end else if (adv && tlp_valid_i) begin
            gnt_tlp = 1'b1;
            if (tlp_sop_i) begin
              err_nxt = 1'b1;
            end
            if (tlp_eop_i) begin
              state_nxt = S_IDLE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    fwd      = 1'b0;
    fwd_sel  = SEL_NONE;
    fwd_data = tlp_data_i;
    if (gnt_ackn) begin
      fwd      = 1'b1;
      fwd_sel  = SEL_ACKN;
      fwd_data = ackn_data_i;
    end else if (gnt_fc) begin
      fwd      = 1'b1;
      fwd_sel  = SEL_FC;
      fwd_data = fc_data_i;
    end else if (gnt_tlp && (state == S_TLP || tlp_sop_i)) begin
      fwd      = 1'b1;
      fwd_sel  = SEL_TLP;
      fwd_data = tlp_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
    end
  end

  // Counts DLLP grants that jumped ahead of a waiting TLP sop.
  always_ff @(posedge clk) begin
    if (rst) begin
      dllp_cnt <= '0;
    end else if (gnt_tlp || !tlp_valid_i) begin
      dllp_cnt <= '0;
    end else if ((gnt_ackn || gnt_fc) && tlp_sop_i && (dllp_cnt < CNT_MAX)) begin
      dllp_cnt <= dllp_cnt + 1'b1;
    end
  end

`ifdef DLL_SCHED_FC_TIMER_EN
  localparam int TMR_W = $clog2(FC_TIMER_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(FC_TIMER_CYCLES);

  logic [TMR_W-1:0] fc_tmr;
  logic             fc_timeout_q;
  logic             fc_boost_q;

  // Down-counter: reaching 1 means FC_TIMER_CYCLES link-up cycles passed
  // without an FC grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      fc_tmr       <= TMR_LOAD;
      fc_timeout_q <= 1'b0;
      fc_boost_q   <= 1'b0;
    end else begin
      fc_timeout_q <= 1'b0;
      if (!dl_up_i || gnt_fc) begin
        fc_tmr     <= TMR_LOAD;
        fc_boost_q <= 1'b0;
      end else if (fc_tmr == TMR_W'(1)) begin
        fc_tmr       <= TMR_LOAD;
        fc_timeout_q <= 1'b1;
        fc_boost_q   <= 1'b1;
      end else begin
        fc_tmr <= fc_tmr - 1'b1;
      end
    end
  end

  assign fc_timeout_o = fc_timeout_q;
  assign fc_boost     = fc_boost_q;
`else
  assign fc_timeout_o = 1'b0;
  assign fc_boost     = 1'b0;
`endif

  dll_tx_out_reg #(
    .WIDTH(PIPE_DATA_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load_valid (fwd),
    .load_sel   (fwd_sel),
    .load_data  (fwd_data),
    .pipe_ready (pipe_ready_i),
    .adv        (adv),
    .data       (pipe_data_o),
    .valid      (pipe_valid_o),
    .sel        (sel_q)
  );

  assign sel_o       = sel_q;
  assign err_o       = err_q;
  assign tlp_ready_o = gnt_tlp;
  assign ackn_gnt_o  = gnt_ackn;
  assign fc_gnt_o    = gnt_fc;

endmodule

// File: tb/tb_dll_tx_scheduler.sv
// tb_dll_tx_scheduler
// Directed scenarios followed by a randomized phase, all checked cycle by
// cycle against a behavioural model of the arbitration rules and a queue of
// words expected on the PIPE output.
module tb_dll_tx_scheduler;
  import dll_pkg::*;

  localparam int W    = 256;
  localparam int BMAX = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         dl_up;
  logic         tlp_valid, tlp_sop, tlp_eop;
  logic [W-1:0] tlp_data;
  logic         tlp_ready;
  logic         ackn_req;
  logic [W-1:0] ackn_data;
  logic         ackn_gnt;
  logic         fc_req;
  logic [W-1:0] fc_data;
  logic         fc_gnt;
  logic [W-1:0] pipe_data;
  logic         pipe_valid;
  logic         pipe_ready;
  logic [1:0]   sel;
  logic         err;
  logic         fc_timeout;

  always #5 clk = ~clk;

  dll_tx_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .dl_up_i      (dl_up),
    .tlp_valid_i  (tlp_valid),
    .tlp_sop_i    (tlp_sop),
    .tlp_eop_i    (tlp_eop),
    .tlp_data_i   (tlp_data),
    .tlp_ready_o  (tlp_ready),
    .ackn_req_i   (ackn_req),
    .ackn_data_i  (ackn_data),
    .ackn_gnt_o   (ackn_gnt),
    .fc_req_i     (fc_req),
    .fc_data_i    (fc_data),
    .fc_gnt_o     (fc_gnt),
    .pipe_data_o  (pipe_data),
    .pipe_valid_o (pipe_valid),
    .pipe_ready_i (pipe_ready),
    .sel_o        (sel),
    .err_o        (err),
    .fc_timeout_o (fc_timeout)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: who wins the word this cycle (0 none, 1 TLP, 2 ACK/NAK,
  // 3 FC), whether we are inside a packet, the DLLP burst length, and the
  // expected PIPE register contents.
  bit           m_in_pkt;
  int           m_burst;
  bit           m_valid;
  int           m_sel;
  bit           m_err;
  logic [W-1:0] exp_q[$];
  int           w;

  logic         s_tlp, s_ackn, s_fc, s_valid, s_err;
  logic [1:0]   s_sel;
  logic [W-1:0] s_data;

  function automatic int winner();
    bit can_load;
    can_load = !m_valid || pipe_ready;
    if (rst || !can_load) return 0;
    if (m_in_pkt) return (dl_up && tlp_valid) ? 1 : 0;
    if (!dl_up) return fc_req ? 3 : 0;
    if (m_burst >= BMAX && tlp_valid && tlp_sop) return 1;
    if (ackn_req) return 2;
    if (fc_req) return 3;
    if (tlp_valid) return 1;
    return 0;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    bit can_load;
    bit fwd;
    @(negedge clk);
    w       = winner();
    s_tlp   = tlp_ready;
    s_ackn  = ackn_gnt;
    s_fc    = fc_gnt;
    s_valid = pipe_valid;
    s_sel   = sel;
    s_err   = err;
    s_data  = pipe_data;
    check("tlp_ready", tlp_ready, W'(w == 1));
    check("ackn_gnt", ackn_gnt, W'(w == 2));
    check("fc_gnt", fc_gnt, W'(w == 3));
    check("pipe_valid", pipe_valid, W'(m_valid));
    check("sel", sel, W'(m_sel));
    check("err", err, W'(m_err));
    check("fc_timeout", fc_timeout, '0);
    if (m_valid) begin
      check("stream_depth", W'(exp_q.size()), W'(1));
      if (exp_q.size() > 0) check("stream_data", pipe_data, exp_q[0]);
    end
    @(posedge clk);
    if (rst) begin
      m_in_pkt = 0; m_burst = 0; m_valid = 0; m_sel = 0; m_err = 0;
      exp_q.delete();
    end else begin
      can_load = !m_valid || pipe_ready;
      if (m_valid && pipe_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      fwd = (w == 2) || (w == 3) || (w == 1 && (m_in_pkt || tlp_sop));
      if (can_load) begin
        m_valid = fwd;
        m_sel   = fwd ? w : 0;
        if (fwd) exp_q.push_back(w == 1 ? tlp_data : (w == 2 ? ackn_data : fc_data));
      end
      m_err = (w == 1) && (m_in_pkt ? tlp_sop : !tlp_sop);
      if (w == 1 || !tlp_valid) m_burst = 0;
      else if ((w == 2 || w == 3) && tlp_sop && m_burst < BMAX) m_burst++;
      if (m_in_pkt && !dl_up) m_in_pkt = 0;
      else if (w == 1) m_in_pkt = m_in_pkt ? !tlp_eop : (tlp_sop && !tlp_eop);
    end
    #1;
  endtask

  task automatic beat(input bit v, input bit s, input bit e, input logic [W-1:0] d);
    tlp_valid = v; tlp_sop = s; tlp_eop = e; tlp_data = d;
  endtask

  initial begin
    logic [W-1:0] wa, wb, wc, wk, wf;
    int  dllp_n;
    bit  got_tlp;
    int  pkt_len, pkt_idx;
    bit  bad_sop;

    rst = 1; dl_up = 0; pipe_ready = 1;
    beat(0, 0, 0, '0);
    ackn_req = 0; ackn_data = '0; fc_req = 0; fc_data = '0;
    m_in_pkt = 0; m_burst = 0; m_valid = 0; m_sel = 0; m_err = 0; w = 0;
    #1;
    step(); step();
    rst = 0; dl_up = 1;
    step(); step();
    check("idle_valid", s_valid, '0);
    check("idle_sel", s_sel, '0);
    check("idle_data", s_data, '0);
    check("idle_fc_timeout", fc_timeout, '0);

    // Link down: FC goes, TLP sop waits.
    dl_up = 0;
    wa = rand_word(); wf = rand_word();
    beat(1, 1, 1, wa); fc_req = 1; fc_data = wf;
    step();
    check("dlup0_fc_gnt", s_fc, W'(1));
    check("dlup0_tlp_ready", s_tlp, '0);
    fc_req = 0;
    step();
    check("dlup0_sel", s_sel, W'(3));
    check("dlup0_data", s_data, wf);
    beat(0, 0, 0, '0);
    dl_up = 1;
    step();

    // ACK/NAK raised mid-packet waits for eop.
    wa = rand_word(); wb = rand_word(); wc = rand_word(); wk = rand_word();
    beat(1, 1, 0, wa); step();
    beat(1, 0, 0, wb); ackn_req = 1; ackn_data = wk; step();
    check("ack_wait_b", s_ackn, '0);
    beat(1, 0, 1, wc); step();
    check("ack_wait_c", s_ackn, '0);
    check("ack_c_ready", s_tlp, W'(1));
    beat(0, 0, 0, '0); step();
    check("ack_after_c", s_ackn, W'(1));
    check("ack_c_on_pipe", s_data, wc);
    ackn_req = 0; step();
    check("ack_sel", s_sel, W'(2));
    check("ack_data", s_data, wk);
    step();

    // Starvation bound with alternating DLLP requests.
    beat(1, 1, 1, rand_word());
    dllp_n = 0; got_tlp = 0;
    for (int i = 0; i < 20 && !got_tlp; i++) begin
      ackn_req = (i % 2 == 0); ackn_data = rand_word();
      fc_req   = (i % 2 == 1); fc_data   = rand_word();
      step();
      if (s_ackn || s_fc) dllp_n++;
      if (s_tlp) got_tlp = 1;
    end
    check("burst_dllp_count", W'(dllp_n), W'(BMAX));
    check("burst_tlp_granted", W'(got_tlp), W'(1));
    ackn_req = 0; fc_req = 0; beat(0, 0, 0, '0);
    step(); step();

    // Backpressure mid-packet.
    wa = rand_word(); wb = rand_word(); wc = rand_word();
    beat(1, 1, 0, wa); step();
    beat(1, 0, 0, wb); step();
    beat(1, 0, 0, wc); pipe_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_ready", s_tlp, '0);
      check("bp_valid", s_valid, W'(1));
      check("bp_hold", s_data, wb);
    end
    pipe_ready = 1; step();
    check("bp_resume", s_tlp, W'(1));
    beat(1, 0, 1, rand_word()); step();
    beat(0, 0, 0, '0); step(); step();

    // DL_up drops after the first beat of a 4-beat TLP.
    beat(1, 1, 0, rand_word()); step();
    dl_up = 0; beat(1, 0, 0, rand_word()); step();
    check("dldrop_ready", s_tlp, '0);
    step();
    check("dldrop_ready_idle", s_tlp, '0);
    dl_up = 1; wa = rand_word(); beat(1, 1, 1, wa); step();
    check("relink_sop_ready", s_tlp, W'(1));
    beat(0, 0, 0, '0); step();
    check("relink_err", s_err, '0);
    check("relink_sel", s_sel, W'(1));
    check("relink_data", s_data, wa);

    // Reset mid-packet drops the in-flight word.
    beat(1, 1, 0, rand_word()); step();
    rst = 1; beat(1, 0, 0, rand_word()); step();
    rst = 0; beat(0, 0, 0, '0); step();
    check("rstmid_valid", s_valid, '0);
    check("rstmid_sel", s_sel, '0);
    step();

    // Randomized phase.
    pkt_len = $urandom_range(1, 5); pkt_idx = 0; bad_sop = 0;
    tlp_data = rand_word();
    for (int c = 0; c < 3000; c++) begin
      if (w == 2) ackn_req = 0;
      if (w == 3) fc_req = 0;
      if (!ackn_req && $urandom_range(0, 99) < 20) begin ackn_req = 1; ackn_data = rand_word(); end
      if (!fc_req && $urandom_range(0, 99) < 15) begin fc_req = 1; fc_data = rand_word(); end
      if (w == 1) begin
        pkt_idx++;
        if (pkt_idx >= pkt_len) begin pkt_idx = 0; pkt_len = $urandom_range(1, 5); end
        tlp_data = rand_word();
        bad_sop  = ($urandom_range(0, 99) < 3);
      end
      if (rst || !dl_up) pkt_idx = 0;
      tlp_valid  = ($urandom_range(0, 99) < 85);
      tlp_sop    = (pkt_idx == 0) ^ bad_sop;
      tlp_eop    = (pkt_idx == pkt_len - 1);
      pipe_ready = ($urandom_range(0, 99) < 75);
      if (dl_up) dl_up = ($urandom_range(0, 99) >= 1);
      else       dl_up = ($urandom_range(0, 99) < 10);
      rst = ($urandom_range(0, 999) < 3);
      step();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
